// File: rtl/prog_ctr_fetch.sv
// Program counter / fetch sequencer (IDLE/LOAD/RUN/DONE); a taken branch redirects PC one cycle later, with no delay slot.
// Define BRANCH_REL_EN to treat branch-LUT entries as signed PC offsets instead of absolute targets.
module prog_ctr_fetch #(
  parameter int PC_W      = 10,
  parameter int IDX_W     = 5,
  parameter int LUT_DEPTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             branch,
  input  logic             BrTaken,
  input  logic [IDX_W-1:0] BrIdx,
  input  logic             Halt,
  input  logic             LutWe,
  input  logic [IDX_W-1:0] LutAddr,
  input  logic [PC_W-1:0]  LutData,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [PC_W-1:0]                pc_q, pc_d;
  logic [PC_W-1:0]                br_target;
  logic                           running_q, running_d;
  logic                           done_q, done_d;
  logic [LUT_DEPTH-1:0][PC_W-1:0] lut_q, lut_d;

  // Branch reads the array state, so a same-cycle write to that index only lands next cycle.
`ifdef BRANCH_REL_EN
  assign br_target = pc_q + lut_q[BrIdx];
`else
  assign br_target = lut_q[BrIdx];
`endif

  always_comb begin
    lut_d = lut_q;
    if (LutWe) begin
      lut_d[LutAddr] = LutData;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (Start) begin
      state_d = ST_LOAD;
      pc_d    = '0;
    end else begin
      case (state_q)
        ST_LOAD: state_d = ST_RUN;
        ST_RUN: begin
          if (Halt) begin
            state_d = ST_DONE;
          end else if (branch && BrTaken) begin
            pc_d = br_target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
        default: state_d = state_q;
      endcase
    end
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      lut_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
      lut_q     <= lut_d;
    end
  end

  assign PC      = pc_q;
  assign Running = running_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_prog_ctr_fetch.sv
// Scoreboard bench for prog_ctr_fetch: driver pushes model predictions, monitor pops and compares after each edge.
module tb_prog_ctr_fetch;

  localparam int PC_W  = 10;
  localparam int IDX_W = 5;
  localparam int PC_MOD = 1 << PC_W;
`ifdef BRANCH_REL_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  typedef struct {
    int pc;
    bit run;
    bit done;
  } exp_t;

  logic             Clk;
  logic             rst, start, br, taken, halt, we;
  logic [IDX_W-1:0] idx, waddr;
  logic [PC_W-1:0]  wdata;
  logic [PC_W-1:0]  pc;
  logic             running, done;

  exp_t  exp_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model: plain integers and mode flags.
  int m_pc;
  bit m_run, m_done, m_load;
  int m_lut[32];

  prog_ctr_fetch #(.PC_W(PC_W), .IDX_W(IDX_W), .LUT_DEPTH(32)) dut (
    .Clk(Clk), .Reset(rst), .Start(start), .branch(br), .BrTaken(taken),
    .BrIdx(idx), .Halt(halt), .LutWe(we), .LutAddr(waddr), .LutData(wdata),
    .PC(pc), .Running(running), .Done(done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic quiet();
    rst = 0; start = 0; br = 0; taken = 0; halt = 0; we = 0;
    idx = '0; waddr = '0; wdata = '0;
  endtask

  // Predict the state after the coming edge, queue it, then advance one cycle.
  task automatic cyc(input string tag);
    int   old, off;
    exp_t e;
    old = m_lut[idx];
    if (rst) begin
      m_pc = 0; m_run = 0; m_done = 0; m_load = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
    end else begin
      if (start) begin
        m_load = 1; m_run = 0; m_done = 0; m_pc = 0;
      end else if (m_load) begin
        m_load = 0; m_run = 1;
      end else if (m_run) begin
        if (halt) begin
          m_run = 0; m_done = 1;
        end else if (br && taken) begin
          if (REL) begin
            off  = (old >= PC_MOD / 2) ? old - PC_MOD : old;
            m_pc = (m_pc + off + PC_MOD) % PC_MOD;
          end else begin
            m_pc = old;
          end
        end else begin
          m_pc = (m_pc + 1) % PC_MOD;
        end
      end
      if (we) m_lut[waddr] = int'(wdata);
    end
    e.pc = m_pc; e.run = m_run; e.done = m_done;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge Clk);
    #2;
  endtask

  task automatic lut_wr(input int a, input int d);
    quiet();
    we = 1; waddr = IDX_W'(a); wdata = PC_W'(d);
    cyc("lut_wr");
    quiet();
  endtask

  task automatic restart_to(input int target);
    quiet();
    start = 1;
    cyc("start");
    start = 0;
    cyc("load_to_run");
    repeat (target) cyc("seq");
  endtask

  initial begin : monitor
    exp_t  e;
    string t;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        vectors++;
        if (pc !== PC_W'(e.pc) || running !== e.run || done !== e.done) begin
          miscompares++;
          $display("FAIL %s: got PC=%0h Running=%0b Done=%0b, want PC=%0h Running=%0b Done=%0b",
                   t, pc, running, done, e.pc, e.run, e.done);
        end
      end
    end
  end

  initial begin : driver
    quiet();
    foreach (m_lut[i]) m_lut[i] = 0;
    m_pc = 0; m_run = 0; m_done = 0; m_load = 0;

    rst = 1;
    cyc("reset");
    cyc("reset");
    rst = 0;
    cyc("idle_hold");

    // Start held 3 cycles, then free-running fetch.
    start = 1;
    repeat (3) cyc("start_held");
    start = 0;
    repeat (5) cyc("first_fetch");

    // Every LUT entry reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      br = 1; taken = 1; idx = IDX_W'(i);
      cyc("lut_zero");
    end
    quiet();

    // Taken and not-taken branch from PC=7.
    lut_wr(3, 'h120);
    restart_to(7);
    br = 1; taken = 1; idx = 3;
    cyc("br_taken");
    quiet();
    restart_to(7);
    br = 1; taken = 0; idx = 3;
    cyc("br_not_taken");
    quiet();

    // Halt beats a taken branch; branch/Halt ignored in DONE; Start leaves DONE.
    restart_to(5);
    halt = 1; br = 1; taken = 1; idx = 3;
    cyc("halt_vs_branch");
    cyc("done_hold");
    quiet();
    cyc("done_hold");
    start = 1; halt = 1;
    cyc("done_restart");
    quiet();

    // PC wrap at the top of the address space.
    restart_to(PC_MOD - 1);
    cyc("pc_wrap");

    // Same-cycle write and branch through the same index uses the old entry.
    lut_wr(2, 'h055);
    restart_to(3);
    we = 1; waddr = 2; wdata = 'h0AA; br = 1; taken = 1; idx = 2;
    cyc("wr_same_cycle_old");
    quiet();
    br = 1; taken = 1; idx = 2;
    cyc("wr_next_cycle_new");
    quiet();

    // Offset-style entries (negative and wrapping when relative).
    lut_wr(1, 'h3FC);
    restart_to('h10);
    br = 1; taken = 1; idx = 1;
    cyc("br_lut1_neg");
    quiet();
    lut_wr(1, 'h005);
    restart_to('h3FE);
    br = 1; taken = 1; idx = 1;
    cyc("br_lut1_wrap");
    quiet();

    // Reset mid-run aborts to IDLE.
    restart_to(4);
    rst = 1;
    cyc("reset_mid_run");
    rst = 0;
    cyc("after_reset");

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 59) == 0);
      halt  = ($urandom_range(0, 39) == 0);
      br    = ($urandom_range(0, 3) == 0);
      taken = 1'($urandom_range(0, 1));
      idx   = IDX_W'($urandom);
      we    = ($urandom_range(0, 7) == 0);
      waddr = IDX_W'($urandom);
      wdata = PC_W'($urandom);
      cyc("random");
    end
    quiet();

    repeat (3) @(posedge Clk);
    #3;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
